// File: rtl/alu_pkg.sv
// Shared opcode encodings for the registered 32-bit ALU.
package alu_pkg;

    // Opcode class, carried in S[3:2]
    localparam logic [1:0] ALU_ARITH = 2'b00;
    localparam logic [1:0] ALU_LOGIC = 2'b01;
    localparam logic [1:0] ALU_SHR   = 2'b10;
    localparam logic [1:0] ALU_SHL   = 2'b11;

    // Arithmetic sub-op, carried in S[1:0]; selects the Y addend
    localparam logic [1:0] ALU_TFR   = 2'b00;
    localparam logic [1:0] ALU_ADD   = 2'b01;
    localparam logic [1:0] ALU_SUBB  = 2'b10;
    localparam logic [1:0] ALU_DEC   = 2'b11;

    // Logic sub-op, carried in S[1:0]
    localparam logic [1:0] ALU_AND   = 2'b00;
    localparam logic [1:0] ALU_OR    = 2'b01;
    localparam logic [1:0] ALU_XOR   = 2'b10;
    localparam logic [1:0] ALU_NOT   = 2'b11;

endpackage

// File: rtl/alu_bit_slice.sv
// One bit of the ALU: full adder with Y select, bitwise logic and shift mux.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       c_i,
    input  logic       left_i,
    input  logic       right_i,
    input  logic [3:0] s,
    output logic       f_i,
    output logic       c_o
);

    logic y;

    // Select the adder's second operand, then form sum/carry and the result mux
    always_comb begin
        y   = 1'b0;
        f_i = 1'b0;
        unique case (s[1:0])
            ALU_TFR:  y = 1'b0;
            ALU_ADD:  y = b_i;
            ALU_SUBB: y = ~b_i;
            ALU_DEC:  y = 1'b1;
            default:  y = 1'b0;
        endcase

        // Carry ripples for every op; the top gates COUT for non-arithmetic classes
        c_o = (a_i & y) | (c_i & (a_i ^ y));

        unique case (s[3:2])
            ALU_ARITH: f_i = a_i ^ y ^ c_i;
            ALU_LOGIC: begin
                unique case (s[1:0])
                    ALU_AND: f_i = a_i & b_i;
                    ALU_OR:  f_i = a_i | b_i;
                    ALU_XOR: f_i = a_i ^ b_i;
                    ALU_NOT: f_i = ~a_i;
                    default: f_i = 1'b0;
                endcase
            end
            ALU_SHR:   f_i = left_i;
            ALU_SHL:   f_i = right_i;
            default:   f_i = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu32_registered.sv
// 32-bit bit-sliced ripple-carry ALU with a single output register stage.
module alu32_registered
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             DL,
    input  logic             DR,
    input  logic [3:0]       S,
    output logic [WIDTH-1:0] F,
    output logic             COUT
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] f_c;
    logic             cout_c;

    assign carry[0] = CIN;
    assign cout_c   = (S[3:2] == ALU_ARITH) & carry[WIDTH];

    // Slice array: MSB takes DL as its left neighbour, LSB takes DR as its right
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_slice
        logic left_bit;
        logic right_bit;

        if (i == int'(WIDTH) - 1) begin : g_msb
            assign left_bit = DL;
        end else begin : g_mid_l
            assign left_bit = A[i+1];
        end

        if (i == 0) begin : g_lsb
            assign right_bit = DR;
        end else begin : g_mid_r
            assign right_bit = A[i-1];
        end

        alu_bit_slice u_slice (
            .a_i     (A[i]),
            .b_i     (B[i]),
            .c_i     (carry[i]),
            .left_i  (left_bit),
            .right_i (right_bit),
            .s       (S),
            .f_i     (f_c[i]),
            .c_o     (carry[i+1])
        );
    end

    // Output register; async reset clears result and carry immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            F    <= '0;
            COUT <= 1'b0;
        end else begin
            F    <= f_c;
            COUT <= cout_c;
        end
    end

endmodule

// File: tb/tb_alu32_registered.sv
// Self-checking bench for alu32_registered: directed corners plus random back-to-back vectors.
module tb_alu32_registered;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic        CIN;
    logic        DL;
    logic        DR;
    logic [3:0]  S;
    logic [31:0] F;
    logic        COUT;

    int total;
    int bad;

    alu32_registered #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .CIN   (CIN),
        .DL    (DL),
        .DR    (DR),
        .S     (S),
        .F     (F),
        .COUT  (COUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: arithmetic as a plain 33-bit sum, everything else straight from the op table
    function automatic logic [32:0] model(input logic [3:0] s, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin,
                                          input logic dl, input logic dr);
        logic [31:0] y;
        logic [32:0] r;
        y = 32'h0;
        r = 33'h0;
        case (s[3:2])
            2'd0: begin
                case (s[1:0])
                    2'd0: y = 32'h0;
                    2'd1: y = b;
                    2'd2: y = ~b;
                    default: y = 32'hFFFF_FFFF;
                endcase
                r = {1'b0, a} + {1'b0, y} + {32'h0, cin};
            end
            2'd1: begin
                case (s[1:0])
                    2'd0: r = {1'b0, a & b};
                    2'd1: r = {1'b0, a | b};
                    2'd2: r = {1'b0, a ^ b};
                    default: r = {1'b0, ~a};
                endcase
            end
            2'd2: r = {1'b0, dl, a[31:1]};
            default: r = {1'b0, a[30:0], dr};
        endcase
        return r;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Present one vector, clock it, then compare against given expectations
    task automatic run_vec(input string tag, input logic [3:0] s, input logic [31:0] a,
                           input logic [31:0] b, input logic cin, input logic dl,
                           input logic dr, input logic [31:0] exp_f, input logic exp_c);
        S = s; A = a; B = b; CIN = cin; DL = dl; DR = dr;
        @(posedge clk);
        #1;
        check32({tag, ".F"}, F, exp_f);
        check1({tag, ".COUT"}, COUT, exp_c);
    endtask

    // Present one vector and compare against the reference model
    task automatic run_model(input string tag, input logic [3:0] s, input logic [31:0] a,
                             input logic [31:0] b, input logic cin, input logic dl,
                             input logic dr);
        logic [32:0] r;
        r = model(s, a, b, cin, dl, dr);
        run_vec(tag, s, a, b, cin, dl, dr, r[31:0], r[32]);
    endtask

    initial begin
        logic [3:0] shr_ops [2];
        logic [3:0] shl_ops [2];
        total = 0;
        bad   = 0;
        shr_ops[0] = 4'h8; shr_ops[1] = 4'hA;
        shl_ops[0] = 4'hC; shl_ops[1] = 4'hD;

        // Reset with arbitrary inputs, no clock edge needed
        rst_n = 1'b0;
        A = 32'hDEAD_BEEF; B = 32'h1234_5678; CIN = 1'b1; DL = 1'b1; DR = 1'b1; S = 4'h1;
        #2;
        check32("reset.F", F, 32'h0);
        check1("reset.COUT", COUT, 1'b0);

        // Load a nonzero result, then assert reset mid-cycle
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("preload", 4'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0,
                32'hFFFF_FFFE, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check32("midreset.F", F, 32'h0);
        check1("midreset.COUT", COUT, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after release loads the current inputs
        run_vec("inc_wrap", 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Arithmetic corners
        run_vec("add_max",   4'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1);
        run_vec("sub_4_3",   4'h2, 32'h4, 32'h3, 1'b1, 1'b0, 1'b0, 32'h1, 1'b1);
        run_vec("sub_3_4",   4'h2, 32'h3, 32'h4, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_vec("dec_0",     4'h3, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_vec("dec_1",     4'h3, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        run_vec("add_nocy",  4'h1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_vec("tfr_cin1",  4'h3, 32'h1357_9BDF, 32'h0, 1'b1, 1'b0, 1'b0, 32'h1357_9BDF, 1'b1);

        // Logic ops with CIN=1 to confirm COUT stays low
        run_vec("and",  4'h4, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
        run_vec("or",   4'h5, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        run_vec("xor",  4'h6, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_vec("not",  4'h7, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);

        // Shifts sweeping {DL,DR}
        for (int k = 0; k < 4; k++) begin
            logic dl;
            logic dr;
            dl = k[1];
            dr = k[0];
            run_vec("shr", shr_ops[k % 2], 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, dl, dr,
                    dl ? 32'h891A_2B3C : 32'h091A_2B3C, 1'b0);
            run_vec("shl", shl_ops[k % 2], 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, dl, dr,
                    dr ? 32'h2468_ACF1 : 32'h2468_ACF0, 1'b0);
        end

        // Back-to-back random vectors, one per cycle
        for (int n = 0; n < 30; n++) begin
            run_model("rand", 4'($urandom_range(0, 15)), $urandom, $urandom,
                      1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu32_registered.md
Name: alu32_registered

Overview:
- 32-bit ALU with arithmetic, logic and single-bit shift operations, selected by a 4-bit opcode.
- Operands are combinational into a single output register stage, so results appear one clock after the inputs are presented.
- Used as the datapath execute unit.
- A bit-sliced structure (one slice per bit, ripple carry) is the reference microarchitecture; any implementation must be bit-exact with it.

Parameters:
- WIDTH, 32, operand/result width; all rules below are written for 32 and generalise to WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- A  input  32  operand A
- B  input  32  operand B
- CIN  input  1  carry-in; used only by arithmetic ops
- DL  input  1  serial data into the MSB on shift-right
- DR  input  1  serial data into the LSB on shift-left
- S  input  4  operation select
- F  output  32  registered result
- COUT  output  1  registered carry-out; 0 for logic/shift ops

Behaviour:
- Reset: while rst_n=0, F=0 and COUT=0 immediately (asynchronous), held until release.
- Normal: at each rising clk, F/COUT load the combinational result of the current A, B, CIN, DL, DR, S.
  - Latency is 1 cycle.
  - No enable and no handshake; a new operation may be issued every cycle.
- Arithmetic, S[3:2]=00:
  - Compute {COUT,F} = A + Y + CIN as a 33-bit sum, where Y is selected by S[1:0].
  - S[1:0]=00: Y=0. Transfer A (CIN=0) or increment A (CIN=1).
  - S[1:0]=01: Y=B. Add (CIN=0) or add+1 (CIN=1).
  - S[1:0]=10: Y=~B. Gives A-B-1 (CIN=0) or A-B (CIN=1). COUT=1 means no borrow (A>=B for CIN=1).
  - S[1:0]=11: Y=32'hFFFFFFFF. Decrement A (CIN=0) or transfer A (CIN=1).
  - Wrap-around is modulo 2^32. No overflow flag.
- Logic, S[3:2]=01 (CIN, DL, DR ignored; COUT=0):
  - S[1:0]=00: A&B
  - S[1:0]=01: A|B
  - S[1:0]=10: A^B
  - S[1:0]=11: ~A (B ignored)
- Shift right, S[3:2]=10 (S[1:0] ignored): F={DL, A[31:1]}, COUT=0. A[0] is discarded.
- Shift left, S[3:2]=11 (S[1:0] ignored): F={A[30:0], DR}, COUT=0. A[31] is discarded.
- No X propagation from unused inputs; F/COUT depend only on the inputs listed for the active op.
- Reset asserted mid-stream clears outputs at once. The first edge after release loads the current inputs.

Decomposition:
- Shared package alu_pkg:
  - Opcode-class constants: ALU_ARITH=2'b00, ALU_LOGIC=2'b01, ALU_SHR=2'b10, ALU_SHL=2'b11.
  - Arithmetic sub-op constants: ALU_TFR, ALU_ADD, ALU_SUBB, ALU_DEC.
  - Logic sub-op constants: ALU_AND, ALU_OR, ALU_XOR, ALU_NOT.
- Sub-module alu_bit_slice:
  - Inputs: a_i, b_i, c_i, left-neighbour bit, right-neighbour bit, S.
  - Outputs: f_i, c_o.
  - Instantiated WIDTH times via generate with a ripple carry chain.
  - Bit 31's left-neighbour input is DL; bit 0's right-neighbour input is DR.
  - COUT is taken from the bit-31 carry, gated to 0 for non-arithmetic ops.
- Top level holds only the slice array and the output register.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs -> F=0, COUT=0 without a clock edge. After release, A=FFFFFFFF, S=0, CIN=1 -> next edge F=00000000, COUT=1.
- Arithmetic corners (each checked one cycle later):
  - S=1, A=B=FFFFFFFF, CIN=0 -> F=FFFFFFFE, COUT=1
  - S=2, A=4, B=3, CIN=1 -> F=1, COUT=1
  - S=2, A=3, B=4, CIN=1 -> F=FFFFFFFF, COUT=0
  - S=3, A=0, CIN=0 -> F=FFFFFFFF, COUT=0
  - S=3, A=1, CIN=0 -> F=0, COUT=1
  - S=1, A=80000000, B=7FFFFFFF, CIN=0 -> F=FFFFFFFF, COUT=0
- Logic:
  - S=4, A=0F0F0F0F, B=F0F0F0F0 -> F=00000000
  - S=5, same operands -> F=FFFFFFFF
  - S=6, A=AAAAAAAA, B=55555555 -> F=FFFFFFFF
  - S=7, A=0 -> F=FFFFFFFF
  - COUT=0 in all logic cases, even with CIN=1.
- Shifts with A=12345678, sweeping {DL,DR} over all 4 values:
  - S=8 or A, DL=0 -> F=091A2B3C; DL=1 -> F=891A2B3C
  - S=C or D, DR=0 -> F=2468ACF0; DR=1 -> F=2468ACF1
  - COUT=0 throughout.
- Back-to-back pipelining: change S/A/B every cycle for 30 random vectors -> each output equals a golden behavioural model of the previous cycle's inputs. Compare F always, and COUT only when S[3:2]=00 (COUT must be 0 otherwise).
